// File: rtl/ext_reg_access_ctrl_if.sv
// CPU-side request/response channel and external register block strobe/ack
// channel of ext_reg_access_ctrl, bundled as one interface.
interface ext_reg_access_ctrl_if #(
  parameter int WIDTH    = 32,
  parameter int SUBWORDS = 1
);
  localparam int SUB_W = (SUBWORDS > 1) ? $clog2(SUBWORDS) : 1;

  logic                cpu_req_valid;
  logic                cpu_req_ready;
  logic                cpu_req_is_wr;
  logic [SUB_W-1:0]    cpu_req_sub;
  logic [WIDTH-1:0]    cpu_wr_data;
  logic [WIDTH-1:0]    cpu_wr_biten;
  logic                cpu_resp_valid;
  logic                cpu_resp_ready;
  logic                cpu_resp_is_wr;
  logic [WIDTH-1:0]    cpu_resp_rdata;
  logic                cpu_resp_err;
  logic [SUBWORDS-1:0] req;
  logic                req_is_wr;
  logic [WIDTH-1:0]    wr_data;
  logic [WIDTH-1:0]    wr_biten;
  logic                rd_ack;
  logic [WIDTH-1:0]    rd_data;
  logic                wr_ack;

  modport slave (
    input  cpu_req_valid, cpu_req_is_wr, cpu_req_sub, cpu_wr_data, cpu_wr_biten,
    input  cpu_resp_ready, rd_ack, rd_data, wr_ack,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_is_wr, cpu_resp_rdata, cpu_resp_err,
    output req, req_is_wr, wr_data, wr_biten
  );

  modport master (
    output cpu_req_valid, cpu_req_is_wr, cpu_req_sub, cpu_wr_data, cpu_wr_biten,
    output cpu_resp_ready, rd_ack, rd_data, wr_ack,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_is_wr, cpu_resp_rdata, cpu_resp_err,
    input  req, req_is_wr, wr_data, wr_biten
  );
endinterface

// File: rtl/ext_reg_access_ctrl.sv
// Sequences one CPU access at a time onto an external register block: one-cycle
// one-hot req strobe, matching-ack tracking with timeout, single response.
module ext_reg_access_ctrl #(
  parameter int WIDTH    = 32,
  parameter int SUBWORDS = 1,
  parameter int TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ext_reg_access_ctrl_if.slave  bus
);
  localparam int SUB_W = (SUBWORDS > 1) ? $clog2(SUBWORDS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  biten_q, biten_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ack_match;
  logic              timed_out;
  logic [SUBWORDS-1:0] req_strobe;

  // Only the ack of the latched access type counts; the other one is noise.
  assign ack_match = is_wr_q ? bus.wr_ack : bus.rd_ack;
  assign timed_out = (TIMEOUT > 0) && (cnt_q == TMO);

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    sub_d   = sub_q;
    wdata_d = wdata_q;
    biten_d = biten_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req_valid) begin
          is_wr_d = bus.cpu_req_is_wr;
          sub_d   = bus.cpu_req_sub;
          wdata_d = bus.cpu_wr_data;
          biten_d = bus.cpu_wr_biten;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = CNT_W'(1);
          state_d = REQ;
        end
      end

      REQ, WAIT: begin
        if (ack_match) begin
          rdata_d = is_wr_q ? '0 : bus.rd_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timed_out) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          if (TIMEOUT > 0) cnt_d = cnt_q + 1'b1;
          state_d = WAIT;
        end
      end

      RESP: begin
        if (bus.cpu_resp_ready) begin
          // After a timeout the late ack may still arrive; swallow it in DRAIN.
          if (err_q && (TIMEOUT > 0)) begin
            cnt_d   = CNT_W'(1);
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DRAIN: begin
        if (ack_match || timed_out) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      sub_q   <= '0;
      wdata_q <= '0;
      biten_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      sub_q   <= sub_d;
      wdata_q <= wdata_d;
      biten_q <= biten_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Out-of-range subword indices match no bit, so req stays 0 and the access times out.
  always_comb begin
    req_strobe = '0;
    for (int i = 0; i < SUBWORDS; i++) begin
      req_strobe[i] = (state_q == REQ) && ((SUBWORDS == 1) || (sub_q == SUB_W'(i)));
    end
  end

  assign bus.cpu_req_ready  = rst && (state_q == IDLE);
  assign bus.cpu_resp_valid = (state_q == RESP);
  assign bus.cpu_resp_is_wr = is_wr_q;
  assign bus.cpu_resp_rdata = rdata_q;
  assign bus.cpu_resp_err   = err_q;
  assign bus.req            = req_strobe;
  assign bus.req_is_wr      = is_wr_q;
  assign bus.wr_data        = wdata_q;
  assign bus.wr_biten       = biten_q;

endmodule

// File: tb/tb_ext_reg_access_ctrl.sv
// Directed bench for ext_reg_access_ctrl (SUBWORDS=4, TIMEOUT=16).
module tb_ext_reg_access_ctrl;
  localparam int WIDTH    = 32;
  localparam int SUBWORDS = 4;
  localparam int TIMEOUT  = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ext_reg_access_ctrl_if #(.WIDTH(WIDTH), .SUBWORDS(SUBWORDS)) bus ();

  ext_reg_access_ctrl #(.WIDTH(WIDTH), .SUBWORDS(SUBWORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_wr;
    logic [1:0]  sub;
    logic [31:0] wdata;
    logic [31:0] biten;
    logic [31:0] rdata_ext;
    int          ack_k;       // cycle after req-cycle start with matching ack, -1 none
    int          wrong_k;     // cycle with the opposite ack, -1 none
    int          hold;        // cycles resp_ready is held low
    int          drain_ack_k; // drain cycle with a late matching ack, -1 none
    logic [3:0]  exp_req;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_drain;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_access(input vec_t v);
    int t;
    bit seen;
    int n;
    bus.cpu_req_is_wr = v.is_wr;
    bus.cpu_req_sub   = v.sub;
    bus.cpu_wr_data   = v.wdata;
    bus.cpu_wr_biten  = v.biten;
    bus.cpu_req_valid = 1'b1;
    chk("req_ready_idle", bus.cpu_req_ready, 1);
    step();
    bus.cpu_req_valid = 1'b0;
    chk("req_strobe", bus.req, v.exp_req);
    chk("req_is_wr", bus.req_is_wr, v.is_wr);
    chk("wr_data", bus.wr_data, v.wdata);
    chk("wr_biten", bus.wr_biten, v.biten);
    t = 1;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      bus.rd_ack  = 1'b0;
      bus.wr_ack  = 1'b0;
      bus.rd_data = 32'hBADBAD00;
      if (k == v.ack_k) begin
        if (v.is_wr) bus.wr_ack = 1'b1;
        else begin
          bus.rd_ack  = 1'b1;
          bus.rd_data = v.rdata_ext;
        end
      end
      if (k == v.wrong_k) begin
        if (v.is_wr) bus.rd_ack = 1'b1;
        else bus.wr_ack = 1'b1;
      end
      step();
      t++;
      bus.rd_ack = 1'b0;
      bus.wr_ack = 1'b0;
      if (bus.cpu_resp_valid) seen = 1;
      else begin
        chk("req_low_wait", bus.req, 0);
        chk("wr_data_stable", bus.wr_data, v.wdata);
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp_never: got no response expected one within 40 cycles");
      return;
    end
    chk("latency", t, v.exp_lat);
    chk("resp_rdata", bus.cpu_resp_rdata, v.exp_rdata);
    chk("resp_err", bus.cpu_resp_err, v.exp_err);
    chk("resp_is_wr", bus.cpu_resp_is_wr, v.is_wr);
    chk("req_low_resp", bus.req, 0);
    for (int h = 0; h < v.hold; h++) begin
      step();
      chk("hold_valid", bus.cpu_resp_valid, 1);
      chk("hold_rdata", bus.cpu_resp_rdata, v.exp_rdata);
      chk("hold_err", bus.cpu_resp_err, v.exp_err);
      chk("hold_ready", bus.cpu_req_ready, 0);
      chk("hold_req", bus.req, 0);
    end
    bus.cpu_resp_ready = 1'b1;
    step();
    bus.cpu_resp_ready = 1'b0;
    chk("resp_dropped", bus.cpu_resp_valid, 0);
    n = 0;
    while (!bus.cpu_req_ready && n < 40) begin
      if (n == v.drain_ack_k) begin
        bus.rd_ack  = !v.is_wr;
        bus.wr_ack  = v.is_wr;
        bus.rd_data = 32'hDEAD0BAD;
      end
      n++;
      step();
      bus.rd_ack = 1'b0;
      bus.wr_ack = 1'b0;
    end
    chk("drain_len", n, v.exp_drain);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.cpu_req_valid  = 1'b0;
    bus.cpu_req_is_wr  = 1'b0;
    bus.cpu_req_sub    = '0;
    bus.cpu_wr_data    = '0;
    bus.cpu_wr_biten   = '0;
    bus.cpu_resp_ready = 1'b0;
    bus.rd_ack         = 1'b0;
    bus.wr_ack         = 1'b0;
    bus.rd_data        = '0;

    //           wr sub wdata          biten          rdata_ext      ack wrg hld dra req      exp_rdata      err lat drn
    vecs[0] = '{1'b1, 2'd0, 32'hDEADBEEF, 32'hFFFF0000, 32'h0,         0, -1, 0, -1, 4'b0001, 32'h0,         1'b0, 2, 0};
    vecs[1] = '{1'b0, 2'd2, 32'h0,        32'h0,        32'h12345678,  3, -1, 0, -1, 4'b0100, 32'h12345678,  1'b0, 5, 0};
    vecs[2] = '{1'b1, 2'd1, 32'hA5A5A5A5, 32'h0000FFFF, 32'h0,         2,  0, 0, -1, 4'b0010, 32'h0,         1'b0, 4, 0};
    vecs[3] = '{1'b0, 2'd3, 32'h0,        32'h0,        32'h0F0F1234,  0,  0, 5, -1, 4'b1000, 32'h0F0F1234,  1'b0, 2, 0};
    vecs[4] = '{1'b0, 2'd1, 32'h0,        32'h0,        32'h0,        -1, -1, 0, -1, 4'b0010, 32'h0,         1'b1, 17, 16};
    vecs[5] = '{1'b0, 2'd0, 32'h0,        32'h0,        32'h0,        -1,  3, 0,  2, 4'b0001, 32'h0,         1'b1, 17, 3};
    vecs[6] = '{1'b0, 2'd0, 32'h0,        32'h0,        32'hCAFEF00D,  1, -1, 0, -1, 4'b0001, 32'hCAFEF00D,  1'b0, 3, 0};
    vecs[7] = '{1'b1, 2'd3, 32'h13579BDF, 32'hF0F0F0F0, 32'h0,         4,  1, 0, -1, 4'b1000, 32'h0,         1'b0, 6, 0};

    // Reset state.
    step();
    step();
    chk("rst_req", bus.req, 0);
    chk("rst_req_ready", bus.cpu_req_ready, 0);
    chk("rst_resp_valid", bus.cpu_resp_valid, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_wr_biten", bus.wr_biten, 0);
    chk("rst_req_is_wr", bus.req_is_wr, 0);
    chk("rst_rdata", bus.cpu_resp_rdata, 0);
    chk("rst_err", bus.cpu_resp_err, 0);
    rst = 1'b1;
    step();
    chk("rst_release_ready", bus.cpu_req_ready, 1);

    // Ack while idle is ignored.
    bus.rd_ack = 1'b1;
    step();
    bus.rd_ack = 1'b0;
    chk("idle_ack_ignored", bus.cpu_resp_valid, 0);

    for (int i = 0; i < 8; i++) do_access(vecs[i]);

    // Reset while waiting for an ack abandons the access silently.
    bus.cpu_req_is_wr = 1'b0;
    bus.cpu_req_sub   = 2'd1;
    bus.cpu_wr_data   = 32'h11112222;
    bus.cpu_wr_biten  = 32'hFFFFFFFF;
    bus.cpu_req_valid = 1'b1;
    step();
    bus.cpu_req_valid = 1'b0;
    chk("mid_rst_req", bus.req, 4'b0010);
    step();
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_req_low", bus.req, 0);
    chk("mid_rst_resp", bus.cpu_resp_valid, 0);
    chk("mid_rst_wr_data", bus.wr_data, 0);
    chk("mid_rst_biten", bus.wr_biten, 0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst_ready", bus.cpu_req_ready, 1);
      chk("post_rst_no_resp", bus.cpu_resp_valid, 0);
    end
    do_access(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ext_reg_access_ctrl.md
Name: ext_reg_access_ctrl

Overview:
- Synthesizable request sequencer between the regblock CPU-side access path and an external register block.
- Converts a valid/ready single-access request into a one-cycle one-hot subword strobe.
- Tracks the external block's independent rd_ack/wr_ack with a bounded timeout, then returns exactly one response per request to the CPU side.
- Sits directly upstream of the external register model/hardware and drives its req/req_is_wr/wr_data/wr_biten inputs.

Parameters:
- WIDTH, 32: data and bit-enable width.
- SUBWORDS, 1: number of subwords; width of the one-hot req strobe.
- TIMEOUT, 16: cycles to wait for an ack after the req cycle. 0 disables the timeout (wait forever).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- cpu_req_valid  input  1  access request valid
- cpu_req_ready  output  1  request accepted when valid&ready
- cpu_req_is_wr  input  1  1=write, 0=read
- cpu_req_sub  input  max(1,$clog2(SUBWORDS))  subword index
- cpu_wr_data  input  WIDTH  write data
- cpu_wr_biten  input  WIDTH  write bit enables
- cpu_resp_valid  output  1  response valid, held until ready
- cpu_resp_ready  input  1  response consumed
- cpu_resp_is_wr  output  1  response type
- cpu_resp_rdata  output  WIDTH  read data (0 for writes and errors)
- cpu_resp_err  output  1  timeout error
- req  output  SUBWORDS  one-hot strobe to external block
- req_is_wr  output  1  access type to external block
- wr_data  output  WIDTH  registered write data
- wr_biten  output  WIDTH  registered bit enables
- rd_ack  input  1  read completion
- rd_data  input  WIDTH  read data, valid only while rd_ack=1
- wr_ack  input  1  write completion

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE; all outputs 0, except cpu_req_ready=1 after reset releases.
  - Timeout counter is cleared.
  - Reset mid-transaction abandons it silently: no response is issued and req drops to 0 on the next edge.
- States: IDLE, REQ, WAIT, RESP, DRAIN.
- IDLE:
  - cpu_req_ready=1.
  - On valid&ready at edge N: latch is_wr, sub, data, biten; go to REQ.
  - Acks arriving in IDLE are ignored.
- REQ (cycle N+1):
  - req = 1<<sub for exactly one cycle; req_is_wr, wr_data, wr_biten are driven from the latch.
  - An ack of the matching type sampled at the end of this cycle completes the access; otherwise go to WAIT.
- WAIT:
  - req=0. req_is_wr, wr_data and wr_biten stay stable until completion.
  - Only a matching ack counts: wr_ack for writes, rd_ack for reads. The opposite ack is ignored.
  - On a matching ack: capture rd_data (reads) and go to RESP.
  - Timeout counter starts at 1 in the REQ cycle and increments each cycle without a matching ack.
  - If TIMEOUT>0 and the counter reaches TIMEOUT without an ack: go to RESP with err=1, rdata=0.
- RESP:
  - cpu_resp_valid=1; is_wr, rdata and err are held stable until cpu_resp_ready.
  - On ready with err=0: go to IDLE.
  - On ready with err=1: go to DRAIN.
  - Acks arriving in RESP after a successful completion are ignored.
- DRAIN:
  - cpu_req_ready=0 for TIMEOUT cycles, or until one matching ack is seen (that ack is discarded), whichever comes first; then go to IDLE.
  - Prevents a late ack from completing the next request.
- Latency: accept at edge N, req high during N+1. With an ack in the req cycle, cpu_resp_valid rises at N+2. Each ack-delay cycle adds one.
- Back-to-back throughput: cpu_req_ready reasserts the cycle after the response handshake. Minimum 3 cycles per access.
- Simultaneous rd_ack and wr_ack: only the one matching the type counts.
- If sub>=SUBWORDS, req=0, no ack arrives, and the access ends in timeout.
- With SUBWORDS=1, cpu_req_sub is ignored and req=1.

Test Plan:
- Write sub=0, data=0xDEADBEEF, biten=0xFFFF0000, wr_ack in the req cycle -> req=1 for one cycle, wr_data/wr_biten match, cpu_resp_valid at N+2, err=0, is_wr=1, rdata=0.
- Read sub=2 (SUBWORDS=4), rd_ack+rd_data=0x12345678 three cycles after req -> req=4'b0100 for one cycle, resp at N+5, rdata=0x12345678, err=0.
- Read with no ack, TIMEOUT=16 -> resp err=1, rdata=0, 16 cycles after the req cycle. Ack injected 2 cycles after the response is consumed -> discarded in DRAIN; the next read returns its own data.
- Write with rd_ack pulsed first, then wr_ack 2 cycles later -> completes only on wr_ack.
- cpu_resp_ready held low 5 cycles -> response fields stable, cpu_req_ready=0 throughout, no second req pulse.
- rst=0 driven in WAIT -> req/outputs 0 next edge, no response issued. A subsequent write completes normally.
